vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates VGA raster timing (hsync, vsync, blank, pixel coordinates) from the system clock via a pixel clock-enable.
//  Directly upstream of the vsync PIO: vs_level drives its in_port, so software sees one rising edge per frame
//  (vertical-sync start) and uses it for frame-buffer swaps. Also feeds the pixel-fetch/colour-mapper stage with draw_x/draw_y.
// PARAMETERS
//  H_VISIBLE  640  active pixels per line
//  H_FRONT    16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BACK     48   horizontal back porch (pixels); H_TOTAL = sum = 800
//  V_VISIBLE  480  active lines per frame
//  V_FRONT    10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BACK     33   vertical back porch (lines); V_TOTAL = sum = 525
//  CLK_DIV    2    clk cycles per pixel (>=1); 50 MHz / 2 = 25 MHz pixel rate
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   reset, asynchronous, active-low
//  enable       in   1   run raster; low = synchronous park at (0,0), idle outputs
//  pix_ce       out  1   one-clk pulse per pixel; all other outputs change only in cycles where pix_ce=1
//  hsync_n      out  1   horizontal sync, active-low
//  vsync_n      out  1   vertical sync, active-low
//  vs_level     out  1   vertical sync, active-high (to vsync PIO in_port)
//  blank_n      out  1   1 = visible region
//  draw_x       out  10  current pixel column, 0..H_TOTAL-1
//  draw_y       out  10  current line, 0..V_TOTAL-1
//  frame_start  out  1   one-clk pulse, coincident with pix_ce, when raster enters (0,0)
// BEHAVIOUR
//  Reset (async): div counter=0, draw_x=draw_y=0, hsync_n=vsync_n=1, vs_level=0, blank_n=0, pix_ce=0, frame_start=0.
//  Divider: div counts 0..CLK_DIV-1 while enable=1; pix_ce=1 in the clk cycle where div==CLK_DIV-1. CLK_DIV=1 -> pix_ce=enable.
//  Counters (on pix_ce): draw_x increments; at H_TOTAL-1 wraps to 0 and draw_y increments; draw_y wraps to 0 after V_TOTAL-1.
//  Outputs are registered and decoded from the NEXT counter values, so each is aligned with draw_x/draw_y in the same cycle:
//   hsync_n = 0 iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC   (656..751 default)
//   vsync_n = 0 iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC   (490..491 default); vs_level = ~vsync_n
//   blank_n = 1 iff x < H_VISIBLE and y < V_VISIBLE
//  frame_start: asserted for exactly the pix_ce cycle in which counters wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0).
//   Not asserted on leaving reset or on re-enable (first frame after enable has no frame_start).
//  Latency: enable rising -> first pix_ce after CLK_DIV clk cycles; counters stay (0,0) until then, blank_n=0 until then.
//  enable falling (any point, mid-line/mid-frame): next clk, div=0, counters=(0,0), outputs idle as at reset.
//  Reset mid-operation: immediate idle as above; no partial sync pulse extended.
//  Width: counters 10 bits; H_TOTAL, V_TOTAL must be <=1024 (elaboration-time check, $error otherwise).
//  vs_level rises exactly once per frame -> downstream edge capture sets once per V_TOTAL*H_TOTAL*CLK_DIV clks (840000).
// STRUCTURE
//  Package vga_timing_pkg: default timing constants, derived H_TOTAL/V_TOTAL, sync-window start/end localparams, coord width.
//  Sub-module vga_pix_ce_div (CLK_DIV counter -> pix_ce, cleared by ~enable); remainder (counters, decode, regs) in top.
// TESTING
//  1 Reset then enable=1, CLK_DIV=2: first pix_ce at clk 2; draw_x steps 0,1,2 every 2 clks; blank_n=1 at (0,0) once running.
//  2 Full line: hsync_n low for x=656..751 (96 pixels, 192 clks); blank_n=0 for x=640..799; draw_y increments at x 799->0.
//  3 Full frame: vsync_n low / vs_level high for y=490..491 only; frame_start pulses once at 840000 clks; one vs_level rise.
//  4 Deassert enable at (700,491) (inside both syncs): next clk hsync_n=vsync_n=1, vs_level=0, counters 0; re-enable -> no frame_start.
//  5 Assert reset_n=0 mid-line asynchronously: outputs idle without waiting for clk; release -> behaviour as scenario 1.
//  6 CLK_DIV=1, small params (H 8/2/2/2, V 4/1/1/1): pix_ce every clk; check sync windows and wrap at H_TOTAL=14, V_TOTAL=7.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, coordinate type and raster state for the timing generator.
// Defaults are 640x480 at a 25 MHz pixel rate from a 50 MHz system clock.
package vga_timing_pkg;

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned COORD_MAX = 1 << COORD_W;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;
   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;
   localparam int unsigned CLK_DIV_DEF   = 2;

   localparam int unsigned H_TOTAL_DEF  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int unsigned V_TOTAL_DEF  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
   localparam int unsigned HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
   localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
   localparam int unsigned VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
   localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

   typedef logic [COORD_W-1:0] coord_t;

   // IDLE: parked at (0,0) waiting for the first pixel tick; RUN: raster advancing.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } raster_state_t;

   typedef struct packed {
      logic hsync_n;
      logic vsync_n;
      logic blank_n;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0};

   // Half-open window test lo <= v < hi.
   function automatic logic in_window(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_pix_ce_div.sv
// Pixel clock-enable divider: one tick every CLK_DIV clk cycles while enabled.
// Cleared synchronously whenever enable is low so the first tick lands CLK_DIV cycles after enable.
module vga_pix_ce_div #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic tick_c
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
      end else if (!enable || (div_q == DIV_LAST)) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   assign tick_c = enable && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, sync/blank decode and frame-start pulse.
// Every output is registered and decoded from the next counter values, so all stay aligned with draw_x/draw_y.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT   = H_FRONT_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BACK    = H_BACK_DEF,
   parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT   = V_FRONT_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BACK    = V_BACK_DEF,
   parameter int unsigned CLK_DIV   = CLK_DIV_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   output logic               pix_ce,
   output logic               hsync_n,
   output logic               vsync_n,
   output logic               vs_level,
   output logic               blank_n,
   output logic [COORD_W-1:0] draw_x,
   output logic [COORD_W-1:0] draw_y,
   output logic               frame_start
);

   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam coord_t      X_LAST   = COORD_W'(H_TOTAL - 1);
   localparam coord_t      Y_LAST   = COORD_W'(V_TOTAL - 1);

   // Counters are COORD_W bits wide; reject timings that cannot fit.
   if (H_TOTAL > COORD_MAX) begin : g_h_total_check
      $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, COORD_MAX);
   end
   if (V_TOTAL > COORD_MAX) begin : g_v_total_check
      $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, COORD_MAX);
   end
   if (CLK_DIV < 1) begin : g_clk_div_check
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end

   logic          tick_c;
   raster_state_t state_q, state_d;
   coord_t        x_q, x_d;
   coord_t        y_q, y_d;
   sync_t         sync_q, sync_d;
   logic          vs_level_q;
   logic          frame_start_q, frame_start_d;
   logic          pix_ce_q, pix_ce_d;

   vga_pix_ce_div #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_ce_div (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .tick_c  (tick_c)
   );

   function automatic sync_t decode(input coord_t x, input coord_t y);
      sync_t s;
      s.hsync_n = !in_window(32'(x), HS_START, HS_END);
      s.vsync_n = !in_window(32'(y), VS_START, VS_END);
      s.blank_n = (32'(x) < H_VISIBLE) && (32'(y) < V_VISIBLE);
      return s;
   endfunction

   // Next-state, counter advance and output decode.
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      sync_d        = sync_q;
      frame_start_d = 1'b0;
      pix_ce_d      = tick_c;

      case (state_q)
         ST_IDLE: begin
            // First tick after reset or enable starts the raster at (0,0) without a frame pulse.
            if (tick_c) begin
               state_d = ST_RUN;
               x_d     = '0;
               y_d     = '0;
               sync_d  = decode('0, '0);
            end
         end
         ST_RUN: begin
            if (tick_c) begin
               if (x_q == X_LAST) begin
                  x_d = '0;
                  if (y_q == Y_LAST) begin
                     y_d           = '0;
                     frame_start_d = 1'b1;
                  end else begin
                     y_d = y_q + COORD_W'(1);
                  end
               end else begin
                  x_d = x_q + COORD_W'(1);
               end
               sync_d = decode(x_d, y_d);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Dropping enable parks the raster immediately, cutting any sync pulse short.
      if (!enable) begin
         state_d       = ST_IDLE;
         x_d           = '0;
         y_d           = '0;
         sync_d        = SYNC_IDLE;
         frame_start_d = 1'b0;
         pix_ce_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         x_q           <= '0;
         y_q           <= '0;
         sync_q        <= SYNC_IDLE;
         vs_level_q    <= 1'b0;
         frame_start_q <= 1'b0;
         pix_ce_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         sync_q        <= sync_d;
         vs_level_q    <= !sync_d.vsync_n;
         frame_start_q <= frame_start_d;
         pix_ce_q      <= pix_ce_d;
      end
   end

   assign pix_ce      = pix_ce_q;
   assign hsync_n     = sync_q.hsync_n;
   assign vsync_n     = sync_q.vsync_n;
   assign vs_level    = vs_level_q;
   assign blank_n     = sync_q.blank_n;
   assign draw_x      = x_q;
   assign draw_y      = y_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480/CLK_DIV=2 instance and a tiny CLK_DIV=1 instance
// checked against hand-computed vectors and a closed-form raster model on every clock.
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       en_d = 1'b0;
   logic       en_s = 1'b0;

   logic       d_ce, d_hs, d_vs, d_lv, d_bl, d_fs;
   logic [9:0] d_x, d_y;
   logic       s_ce, s_hs, s_vs, s_lv, s_bl, s_fs;
   logic [9:0] s_x, s_y;

   always #5 clk = ~clk;

   vga_timing_gen u_def (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (en_d),
      .pix_ce      (d_ce),
      .hsync_n     (d_hs),
      .vsync_n     (d_vs),
      .vs_level    (d_lv),
      .blank_n     (d_bl),
      .draw_x      (d_x),
      .draw_y      (d_y),
      .frame_start (d_fs)
   );

   vga_timing_gen #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
      .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
      .CLK_DIV   (1)
   ) u_sm (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (en_s),
      .pix_ce      (s_ce),
      .hsync_n     (s_hs),
      .vsync_n     (s_vs),
      .vs_level    (s_lv),
      .blank_n     (s_bl),
      .draw_x      (s_x),
      .draw_y      (s_y),
      .frame_start (s_fs)
   );

   typedef struct packed {
      logic       ce;
      logic       hs_n;
      logic       vs_n;
      logic       vs_lv;
      logic       bl;
      logic       fs;
      logic [9:0] x;
      logic [9:0] y;
   } obs_t;

   typedef struct {
      int cd, hvis, hss, hse, htot, vvis, vss, vse, vtot;
   } tim_t;

   typedef struct {
      int   rel;
      bit   sel;
      obs_t exp;
   } vec_t;

   obs_t got_d, got_s;
   assign got_d = {d_ce, d_hs, d_vs, d_lv, d_bl, d_fs, d_x, d_y};
   assign got_s = {s_ce, s_hs, s_vs, s_lv, s_bl, s_fs, s_x, s_y};

   int   total = 0;
   int   bad = 0;
   int   edge_n = 0;
   int   base_d = 0;
   int   base_s = 0;
   bit   run_d = 1'b0;
   bit   run_s = 1'b0;
   bit   count_on = 1'b0;
   tim_t td, ts;
   vec_t tab[$];

   int   hs_clks = 0, hs_pix = 0, blank_pix = 0, fs_d_cnt = 0;
   int   lv_rises_s = 0, fs_s_cnt = 0;
   logic prev_s_lv = 1'b0;

   function automatic obs_t idle_obs();
      obs_t o;
      o = '0;
      o.hs_n = 1'b1;
      o.vs_n = 1'b1;
      return o;
   endfunction

   function automatic obs_t mk(bit ce, bit hs_n, bit vs_n, bit bl, bit fs, int x, int y);
      obs_t o;
      o.ce = ce; o.hs_n = hs_n; o.vs_n = vs_n; o.vs_lv = !vs_n;
      o.bl = bl; o.fs = fs; o.x = 10'(x); o.y = 10'(y);
      return o;
   endfunction

   // Expected outputs rel clocks after enable rose (closed form, no counters).
   function automatic obs_t model(int rel, tim_t t);
      obs_t o;
      int k, p, x, y;
      o = idle_obs();
      if (rel < t.cd) return o;
      k = (rel - t.cd) / t.cd;
      p = k % (t.htot * t.vtot);
      x = p % t.htot;
      y = p / t.htot;
      o.ce    = ((rel - t.cd) % t.cd) == 0;
      o.x     = 10'(x);
      o.y     = 10'(y);
      o.hs_n  = !(x >= t.hss && x < t.hse);
      o.vs_n  = !(y >= t.vss && y < t.vse);
      o.vs_lv = !o.vs_n;
      o.bl    = (x < t.hvis) && (y < t.vvis);
      o.fs    = o.ce && (k > 0) && (p == 0);
      return o;
   endfunction

   task automatic chk(input string nm, input obs_t got, input obs_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s edge=%0d got ce%b hs%b vs%b lv%b bl%b fs%b x%0d y%0d want ce%b hs%b vs%b lv%b bl%b fs%b x%0d y%0d",
                  nm, edge_n, got.ce, got.hs_n, got.vs_n, got.vs_lv, got.bl, got.fs, got.x, got.y,
                  want.ce, want.hs_n, want.vs_n, want.vs_lv, want.bl, want.fs, want.x, want.y);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // One clock: sample #1 after the edge and compare both instances with the model.
   task automatic step();
      @(posedge clk);
      edge_n++;
      #1;
      chk("scan_def", got_d, run_d ? model(edge_n - base_d, td) : idle_obs());
      chk("scan_small", got_s, run_s ? model(edge_n - base_s, ts) : idle_obs());
      if (count_on) begin
         if (!d_hs && d_y == 10'd0) hs_clks++;
         if (d_ce && !d_hs && d_y == 10'd0) hs_pix++;
         if (d_ce && !d_bl && d_y == 10'd0) blank_pix++;
         if (d_fs) fs_d_cnt++;
         if (s_lv && !prev_s_lv) lv_rises_s++;
         if (s_fs) fs_s_cnt++;
      end
      prev_s_lv = s_lv;
   endtask

   initial begin
      int ti;
      td = '{2, 640, 656, 752, 800, 480, 490, 492, 525};
      ts = '{1, 8, 10, 12, 14, 4, 5, 6, 7};

      // {rel clocks since enable, instance (0 default, 1 small), expected}
      tab.push_back('{1,    1'b0, mk(0, 1, 1, 0, 0, 0, 0)});
      tab.push_back('{1,    1'b1, mk(1, 1, 1, 1, 0, 0, 0)});
      tab.push_back('{2,    1'b0, mk(1, 1, 1, 1, 0, 0, 0)});
      tab.push_back('{2,    1'b1, mk(1, 1, 1, 1, 0, 1, 0)});
      tab.push_back('{3,    1'b0, mk(0, 1, 1, 1, 0, 0, 0)});
      tab.push_back('{4,    1'b0, mk(1, 1, 1, 1, 0, 1, 0)});
      tab.push_back('{6,    1'b0, mk(1, 1, 1, 1, 0, 2, 0)});
      tab.push_back('{8,    1'b1, mk(1, 1, 1, 1, 0, 7, 0)});
      tab.push_back('{9,    1'b1, mk(1, 1, 1, 0, 0, 8, 0)});
      tab.push_back('{11,   1'b1, mk(1, 0, 1, 0, 0, 10, 0)});
      tab.push_back('{12,   1'b1, mk(1, 0, 1, 0, 0, 11, 0)});
      tab.push_back('{13,   1'b1, mk(1, 1, 1, 0, 0, 12, 0)});
      tab.push_back('{15,   1'b1, mk(1, 1, 1, 1, 0, 0, 1)});
      tab.push_back('{57,   1'b1, mk(1, 1, 1, 0, 0, 0, 4)});
      tab.push_back('{71,   1'b1, mk(1, 1, 0, 0, 0, 0, 5)});
      tab.push_back('{85,   1'b1, mk(1, 1, 1, 0, 0, 0, 6)});
      tab.push_back('{98,   1'b1, mk(1, 1, 1, 0, 0, 13, 6)});
      tab.push_back('{99,   1'b1, mk(1, 1, 1, 1, 1, 0, 0)});
      tab.push_back('{100,  1'b1, mk(1, 1, 1, 1, 0, 1, 0)});
      tab.push_back('{1282, 1'b0, mk(1, 1, 1, 0, 0, 640, 0)});
      tab.push_back('{1314, 1'b0, mk(1, 0, 1, 0, 0, 656, 0)});
      tab.push_back('{1315, 1'b0, mk(0, 0, 1, 0, 0, 656, 0)});
      tab.push_back('{1504, 1'b0, mk(1, 0, 1, 0, 0, 751, 0)});
      tab.push_back('{1506, 1'b0, mk(1, 1, 1, 0, 0, 752, 0)});
      tab.push_back('{1600, 1'b0, mk(1, 1, 1, 0, 0, 799, 0)});
      tab.push_back('{1602, 1'b0, mk(1, 1, 1, 1, 0, 0, 1)});

      // Reset held: both instances idle.
      repeat (3) step();

      // Release reset with enable high; run a full default line and many small frames.
      reset_n = 1'b1;
      en_d = 1'b1; en_s = 1'b1;
      base_d = edge_n; base_s = edge_n;
      run_d = 1'b1; run_s = 1'b1;
      count_on = 1'b1;
      ti = 0;
      for (int rel = 1; rel <= 1700; rel++) begin
         step();
         while (ti < tab.size() && tab[ti].rel == rel) begin
            chk($sformatf("vec%0d", ti), tab[ti].sel ? got_s : got_d, tab[ti].exp);
            ti++;
         end
      end
      count_on = 1'b0;
      chk_int("vec_all_applied", ti, 26);
      chk_int("hsync_low_clks", hs_clks, 192);
      chk_int("hsync_low_pixels", hs_pix, 96);
      chk_int("blank_pixels_line0", blank_pix, 160);
      chk_int("def_frame_starts", fs_d_cnt, 0);
      chk_int("small_vs_rises", lv_rises_s, 17);
      chk_int("small_frame_starts", fs_s_cnt, 17);

      // Park both, then bring each inside its sync windows and drop enable there.
      en_d = 1'b0; en_s = 1'b0; run_d = 1'b0; run_s = 1'b0;
      repeat (2) step();
      en_d = 1'b1; base_d = edge_n; run_d = 1'b1;
      repeat (1321) step();
      en_s = 1'b1; base_s = edge_n; run_s = 1'b1;
      repeat (81) step();
      chk("pre_drop_def", got_d, mk(1, 0, 1, 0, 0, 700, 0));
      chk("pre_drop_small", got_s, mk(1, 0, 0, 0, 0, 10, 5));
      en_d = 1'b0; en_s = 1'b0; run_d = 1'b0; run_s = 1'b0;
      step();
      chk("drop_def", got_d, idle_obs());
      chk("drop_small", got_s, idle_obs());

      // Re-enable: raster restarts at (0,0) with no frame_start.
      en_d = 1'b1; en_s = 1'b1;
      base_d = edge_n; base_s = edge_n; run_d = 1'b1; run_s = 1'b1;
      step();
      chk("reen_small_rel1", got_s, mk(1, 1, 1, 1, 0, 0, 0));
      chk("reen_def_rel1", got_d, idle_obs());
      repeat (300) step();

      // Asynchronous reset mid-line: outputs idle before the next clock edge.
      #2;
      reset_n = 1'b0;
      run_d = 1'b0; run_s = 1'b0;
      #1;
      chk("async_rst_def", got_d, idle_obs());
      chk("async_rst_small", got_s, idle_obs());
      repeat (2) step();
      reset_n = 1'b1;
      base_d = edge_n; base_s = edge_n; run_d = 1'b1; run_s = 1'b1;
      repeat (2) step();
      chk("post_rst_def_rel2", got_d, mk(1, 1, 1, 1, 0, 0, 0));
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
